// File: rtl/crc_stream_pkg.sv
// Shared types and bit-level helpers for the streaming CRC engine.
// CRC arithmetic works on a CRC_MAX_W-bit register with the CRC left-aligned at the MSB.
package crc_stream_pkg;

  localparam int CRC_MAX_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [7:0] reflect8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  // Reverses the low 'width' bits of v; the result sits in the low bits.
  function automatic logic [CRC_MAX_W-1:0] reflectCrc(input logic [CRC_MAX_W-1:0] v,
                                                       input int width);
    logic [CRC_MAX_W-1:0] r;
    for (int i = 0; i < CRC_MAX_W; i++) r[i] = v[CRC_MAX_W-1-i];
    return r >> (CRC_MAX_W - width);
  endfunction

  // One byte, MSB first; crc and poly are MSB-aligned so any width shares this code.
  function automatic logic [CRC_MAX_W-1:0] crcByteStep(input logic [CRC_MAX_W-1:0] crc,
                                                        input logic [7:0]           dataByte,
                                                        input logic [CRC_MAX_W-1:0] poly);
    logic [CRC_MAX_W-1:0] c;
    logic                 fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[CRC_MAX_W-1] ^ dataByte[i];
      c  = c << 1;
      if (fb) c = c ^ poly;
    end
    return c;
  endfunction

endpackage

// File: rtl/crc_word_update.sv
// Combinational CRC update over the first byte_cnt_i bytes of a word (first byte at the MSB).
module crc_word_update
  import crc_stream_pkg::*;
#(
  parameter int CRC_WIDTH = 16,
  parameter int DWIDTH    = 32,
  parameter int BCNT_W    = 2
) (
  input  logic [CRC_WIDTH-1:0] crc_i,
  input  logic [DWIDTH-1:0]    word_i,
  input  logic [BCNT_W:0]      byte_cnt_i,
  input  logic [CRC_WIDTH-1:0] poly_i,
  input  logic                 ref_in_i,
  output logic [CRC_WIDTH-1:0] crc_o
);

  localparam int NB = DWIDTH / 8;
  localparam int SH = CRC_MAX_W - CRC_WIDTH;

  logic [CRC_MAX_W-1:0] c;
  logic [CRC_MAX_W-1:0] p;
  logic [7:0]           b;

  always_comb begin
    c = CRC_MAX_W'(crc_i) << SH;
    p = CRC_MAX_W'(poly_i) << SH;
    b = '0;
    for (int i = 0; i < NB; i++) begin
      b = word_i[DWIDTH-1-8*i -: 8];
      if (ref_in_i) b = reflect8(b);
      if (i < int'(byte_cnt_i)) c = crcByteStep(c, b, p);
    end
    crc_o = c[CRC_MAX_W-1 -: CRC_WIDTH];
  end

endmodule

// File: rtl/crc_stream_engine.sv
// Streaming multi-word CRC engine with SOP/EOP framing and per-packet runtime configuration.
// Optional build macro CRC_STREAM_CHECK_EN adds expCrc/crcMatch result comparison.
module crc_stream_engine
  import crc_stream_pkg::*;
#(
  parameter int CRC_WIDTH = 16,
  parameter int DWIDTH    = 32,
  parameter int BCNT_W    = ($clog2(DWIDTH/8) < 1) ? 1 : $clog2(DWIDTH/8)
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic [DWIDTH-1:0]    dataIn,
  input  logic                 inValid,
  output logic                 inReady,
  input  logic                 inSop,
  input  logic                 inEop,
  input  logic [BCNT_W-1:0]    inBytes,
  input  logic [CRC_WIDTH-1:0] genPoly,
  input  logic [CRC_WIDTH-1:0] initXorValue,
  input  logic                 refInEn,
  input  logic                 refOutEn,
  input  logic [CRC_WIDTH-1:0] finalXorValue,
  output logic [CRC_WIDTH-1:0] crcOut,
  output logic                 crcValid,
  output logic                 crcErr,
`ifdef CRC_STREAM_CHECK_EN
  input  logic [CRC_WIDTH-1:0] expCrc,
  output logic                 crcMatch,
`endif
  output logic [1:0]           dbgState
);

  localparam int              NB     = DWIDTH / 8;
  localparam logic [BCNT_W:0] NB_CNT = (BCNT_W+1)'(NB);

  state_t                 state_q, state_d;
  logic                   rdy_q;
  logic [CRC_WIDTH-1:0]   poly_q, poly_d;
  logic [CRC_WIDTH-1:0]   init_q, init_d;
  logic                   refIn_q, refIn_d;
  logic                   refOut_q, refOut_d;
  logic [CRC_WIDTH-1:0]   xor_q, xor_d;
  logic [CRC_WIDTH-1:0]   crc_q, crc_d;
  logic [CRC_WIDTH-1:0]   crcOut_q, crcOut_d;
  logic                   crcValid_q, crcValid_d;
  logic                   crcErr_q, crcErr_d;
`ifdef CRC_STREAM_CHECK_EN
  logic                   match_q, match_d;
`endif

  logic                   accept, sopAcc, finish;
  logic [CRC_WIDTH-1:0]   effPoly, effXor, updCrcIn, crcNext, finalCrc;
  logic                   effRefIn, effRefOut;
  logic [BCNT_W:0]        cntRaw, byteCnt;
  logic [CRC_MAX_W-1:0]   refl;

  // Handshake: a word transfers on a rising clk edge where inValid && inReady;
  // inValid may drop at any time, inReady is low only in reset and in DONE.
  assign inReady  = rdy_q && (state_q != DONE);
  assign accept   = inValid && inReady;
  assign sopAcc   = accept && inSop;
  assign finish   = accept && inEop && (inSop || (state_q == BUSY));
  assign dbgState = state_q;

  // A SOP word uses the live config; later words use the copy captured at SOP.
  assign effPoly   = sopAcc ? genPoly       : poly_q;
  assign effRefIn  = sopAcc ? refInEn       : refIn_q;
  assign effRefOut = sopAcc ? refOutEn      : refOut_q;
  assign effXor    = sopAcc ? finalXorValue : xor_q;
  assign updCrcIn  = sopAcc ? initXorValue  : crc_q;

  always_comb begin
    cntRaw  = {1'b0, inBytes} + (BCNT_W+1)'(1);
    byteCnt = NB_CNT;
    if (inEop) byteCnt = (cntRaw > NB_CNT) ? NB_CNT : cntRaw;
  end

  crc_word_update #(
    .CRC_WIDTH (CRC_WIDTH),
    .DWIDTH    (DWIDTH),
    .BCNT_W    (BCNT_W)
  ) u_word_update (
    .crc_i      (updCrcIn),
    .word_i     (dataIn),
    .byte_cnt_i (byteCnt),
    .poly_i     (effPoly),
    .ref_in_i   (effRefIn),
    .crc_o      (crcNext)
  );

  always_comb begin
    refl     = reflectCrc(CRC_MAX_W'(crcNext), CRC_WIDTH);
    finalCrc = (effRefOut ? refl[CRC_WIDTH-1:0] : crcNext) ^ effXor;
  end

  always_comb begin
    state_d    = state_q;
    poly_d     = poly_q;
    init_d     = init_q;
    refIn_d    = refIn_q;
    refOut_d   = refOut_q;
    xor_d      = xor_q;
    crc_d      = crc_q;
    crcOut_d   = crcOut_q;
    crcValid_d = 1'b0;
    crcErr_d   = 1'b0;
`ifdef CRC_STREAM_CHECK_EN
    match_d    = match_q;
`endif
    if (sopAcc) begin
      poly_d   = genPoly;
      init_d   = initXorValue;
      refIn_d  = refInEn;
      refOut_d = refOutEn;
      xor_d    = finalXorValue;
    end
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (inSop) begin
            crc_d   = crcNext;
            state_d = BUSY;
          end else begin
            crcErr_d = 1'b1;
          end
        end
      end
      BUSY: begin
        if (accept) begin
          crc_d = crcNext;
          if (inSop) crcErr_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (finish) begin
      state_d    = DONE;
      crcOut_d   = finalCrc;
      crcValid_d = 1'b1;
`ifdef CRC_STREAM_CHECK_EN
      match_d    = (finalCrc == expCrc);
`else
`endif
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q    <= IDLE;
      rdy_q      <= 1'b0;
      poly_q     <= '0;
      init_q     <= '0;
      refIn_q    <= 1'b0;
      refOut_q   <= 1'b0;
      xor_q      <= '0;
      crc_q      <= '0;
      crcOut_q   <= '0;
      crcValid_q <= 1'b0;
      crcErr_q   <= 1'b0;
`ifdef CRC_STREAM_CHECK_EN
      match_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rdy_q      <= 1'b1;
      poly_q     <= poly_d;
      init_q     <= init_d;
      refIn_q    <= refIn_d;
      refOut_q   <= refOut_d;
      xor_q      <= xor_d;
      crc_q      <= crc_d;
      crcOut_q   <= crcOut_d;
      crcValid_q <= crcValid_d;
      crcErr_q   <= crcErr_d;
`ifdef CRC_STREAM_CHECK_EN
      match_q    <= match_d;
`endif
    end
  end

  assign crcOut   = crcOut_q;
  assign crcValid = crcValid_q;
  assign crcErr   = crcErr_q;
`ifdef CRC_STREAM_CHECK_EN
  assign crcMatch = match_q;
`endif

endmodule

// File: tb/tb_crc_stream_engine.sv
// Bench for crc_stream_engine: a 16-bit and a 32-bit instance share the word stream,
// each with its own CRC configuration and expected-result queue.
module tb_crc_stream_engine;

  logic        clk = 1'b0;
  logic        rstN;
  logic [31:0] dataIn;
  logic        inValid, inSop, inEop;
  logic [1:0]  inBytes;

  logic        rdy16, ri16, ro16, v16, e16;
  logic [15:0] poly16, init16, xo16, out16, expc16;
  logic [1:0]  st16;
  logic        rdy32, ri32, ro32, v32, e32;
  logic [31:0] poly32, init32, xo32, out32, expc32;
  logic [1:0]  st32;
`ifdef CRC_STREAM_CHECK_EN
  logic        match16, match32;
`endif

  // Packet configuration the bench intends for the next packet.
  logic [15:0] c16_poly, c16_init, c16_xo;
  bit          c16_ri, c16_ro;
  logic [31:0] c32_poly, c32_init, c32_xo;
  bit          c32_ri, c32_ro;

  logic [15:0] exp16_q[$];
  logic [31:0] exp32_q[$];
  int checks = 0;
  int errors = 0;
  int err16_seen = 0;
  int err32_seen = 0;

  always #5 clk = ~clk;

  crc_stream_engine #(.CRC_WIDTH(16), .DWIDTH(32)) u16 (
    .clk(clk), .rstN(rstN), .dataIn(dataIn), .inValid(inValid), .inReady(rdy16),
    .inSop(inSop), .inEop(inEop), .inBytes(inBytes), .genPoly(poly16),
    .initXorValue(init16), .refInEn(ri16), .refOutEn(ro16), .finalXorValue(xo16),
    .crcOut(out16), .crcValid(v16), .crcErr(e16),
`ifdef CRC_STREAM_CHECK_EN
    .expCrc(expc16), .crcMatch(match16),
`endif
    .dbgState(st16)
  );

  crc_stream_engine #(.CRC_WIDTH(32), .DWIDTH(32)) u32 (
    .clk(clk), .rstN(rstN), .dataIn(dataIn), .inValid(inValid), .inReady(rdy32),
    .inSop(inSop), .inEop(inEop), .inBytes(inBytes), .genPoly(poly32),
    .initXorValue(init32), .refInEn(ri32), .refOutEn(ro32), .finalXorValue(xo32),
    .crcOut(out32), .crcValid(v32), .crcErr(e32),
`ifdef CRC_STREAM_CHECK_EN
    .expCrc(expc32), .crcMatch(match32),
`endif
    .dbgState(st32)
  );

  // Reference: textbook CRC over a byte list (byte XORed into the register top, then 8 shifts).
  function automatic logic [31:0] model_crc(input logic [7:0] msg[$], input int w,
                                            input logic [31:0] poly, input logic [31:0] init,
                                            input bit ri, input bit ro, input logic [31:0] xo);
    logic [63:0] c, mask, top, r;
    logic [7:0]  b;
    mask = (64'd1 << w) - 64'd1;
    top  = 64'd1 << (w - 1);
    c    = {32'd0, init} & mask;
    foreach (msg[k]) begin
      b = msg[k];
      if (ri) b = {<<{b}};
      c = c ^ ({56'd0, b} << (w - 8));
      for (int j = 0; j < 8; j++)
        c = ((c & top) != 0) ? (((c << 1) ^ {32'd0, poly}) & mask) : ((c << 1) & mask);
    end
    if (ro) begin
      r = '0;
      for (int j = 0; j < w; j++) r[j] = c[w-1-j];
      c = r;
    end
    c = (c ^ {32'd0, xo}) & mask;
    return c[31:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_cfg();
    poly16 = c16_poly; init16 = c16_init; ri16 = c16_ri; ro16 = c16_ro; xo16 = c16_xo;
    poly32 = c32_poly; init32 = c32_init; ri32 = c32_ri; ro32 = c32_ro; xo32 = c32_xo;
  endtask

  task automatic scramble_cfg();
    poly16 = 16'($urandom); init16 = 16'($urandom); ri16 = 1'($urandom); ro16 = 1'($urandom);
    xo16 = 16'($urandom); poly32 = $urandom; init32 = $urandom; ri32 = 1'($urandom);
    ro32 = 1'($urandom); xo32 = $urandom; expc16 = 16'($urandom); expc32 = $urandom;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      inValid = 1'b0; dataIn = $urandom; inSop = 1'($urandom);
      inEop = 1'($urandom); inBytes = 2'($urandom);
      @(posedge clk); #1;
    end
  endtask

  // Presents one word, waits (bounded) for inReady, returns #1 after the accepting edge.
  task automatic drive_word(input logic [31:0] d, input bit sop, input bit eop,
                            input logic [1:0] nb);
    int waited;
    dataIn = d; inSop = sop; inEop = eop; inBytes = nb; inValid = 1'b1;
    waited = 0;
    while (!rdy16 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!rdy16) chk("ready_timeout", 32'(rdy16), 32'd1);
    @(posedge clk); #1;
    inValid = 1'b0; dataIn = $urandom; inSop = 1'($urandom); inEop = 1'($urandom);
    if (sop) scramble_cfg();
  endtask

  task automatic send_packet(input logic [7:0] msg[$], input int gap_max, input bit flip,
                             input logic [31:0] x16, input logic [31:0] x32);
    int          len, nw, idx;
    logic [31:0] word;
    logic [1:0]  nb;
    bit          eop;
    len = msg.size();
    nw  = (len + 3) / 4;
    apply_cfg();
    for (int w = 0; w < nw; w++) begin
      if (gap_max > 0) idle($urandom_range(0, gap_max));
      for (int j = 0; j < 4; j++) begin
        idx = 4 * w + j;
        word[31-8*j -: 8] = (idx < len) ? msg[idx] : 8'($urandom);
      end
      eop = (w == nw - 1);
      nb  = eop ? 2'(len - 1 - 4 * w) : 2'($urandom);
      if (eop) begin
        exp16_q.push_back(x16[15:0]);
        exp32_q.push_back(x32);
        expc16 = flip ? (x16[15:0] ^ 16'h0001) : x16[15:0];
        expc32 = x32;
      end
      drive_word(word, w == 0, eop, nb);
    end
    chk("ready_low_after_eop", 32'(rdy16), 32'd0);
    chk("ready32_low_after_eop", 32'(rdy32), 32'd0);
    chk("valid16_after_eop", 32'(v16), 32'd1);
    chk("valid32_after_eop", 32'(v32), 32'd1);
`ifdef CRC_STREAM_CHECK_EN
    chk("match16", 32'(match16), 32'(!flip));
    chk("match32", 32'(match32), 32'd1);
`endif
    @(posedge clk); #1;
    chk("ready_high_after_bubble", 32'(rdy16), 32'd1);
    chk("valid16_one_cycle", 32'(v16), 32'd0);
    chk("state_idle_after_done", 32'(st16), 32'd0);
  endtask

  // Scoreboard: every result pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (rstN === 1'b1) begin
      if (v16) begin
        if (exp16_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_valid16 actual=%h required=none", out16);
        end else chk("crc16", 32'(out16), 32'(exp16_q.pop_front()));
      end
      if (v32) begin
        if (exp32_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_valid32 actual=%h required=none", out32);
        end else chk("crc32", out32, exp32_q.pop_front());
      end
      if (e16) err16_seen++;
      if (e32) err32_seen++;
    end
  end

  typedef struct {
    logic [15:0] p16, i16; bit ri16, ro16; logic [15:0] x16, e16;
    logic [31:0] p32, i32; bit ri32, ro32; logic [31:0] x32, e32;
    int gap;
  } vec_t;

  vec_t        tbl[5];
  logic [7:0]  m9[$];
  logic [7:0]  rq[$];
  logic [31:0] r16, r32;

  initial begin
    tbl[0] = '{16'h8005, 16'h0000, 1, 1, 16'h0000, 16'hBB3D,
               32'h04C11DB7, 32'hFFFFFFFF, 1, 1, 32'hFFFFFFFF, 32'hCBF43926, 0};
    tbl[1] = '{16'h1021, 16'hFFFF, 0, 0, 16'h0000, 16'h29B1,
               32'h04C11DB7, 32'hFFFFFFFF, 0, 0, 32'hFFFFFFFF, 32'hFC891918, 3};
    tbl[2] = '{16'h8005, 16'h0000, 0, 0, 16'h0000, 16'hFEE8,
               32'h04C11DB7, 32'hFFFFFFFF, 0, 0, 32'h00000000, 32'h0376E6E7, 0};
    tbl[3] = '{16'h1021, 16'h0000, 0, 0, 16'h0000, 16'h31C3,
               32'h04C11DB7, 32'hFFFFFFFF, 1, 1, 32'hFFFFFFFF, 32'hCBF43926, 2};
    tbl[4] = '{16'h8005, 16'hFFFF, 1, 1, 16'h0000, 16'h4B37,
               32'h04C11DB7, 32'hFFFFFFFF, 0, 0, 32'hFFFFFFFF, 32'hFC891918, 0};
    m9 = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

    // Clock/reset
    rstN = 1'b0; inValid = 1'b0; dataIn = '0; inSop = 0; inEop = 0; inBytes = '0;
    expc16 = '0; expc32 = '0;
    c16_poly = 16'h8005; c16_init = 0; c16_ri = 1; c16_ro = 1; c16_xo = 0;
    c32_poly = 32'h04C11DB7; c32_init = '1; c32_ri = 1; c32_ro = 1; c32_xo = '1;
    apply_cfg();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(rdy16), 32'd0);
    chk("rst_crcout16", 32'(out16), 32'd0);
    chk("rst_crcout32", out32, 32'd0);
    chk("rst_valid", 32'(v16), 32'd0);
    chk("rst_err", 32'(e16), 32'd0);
    chk("rst_state", 32'(st16), 32'd0);
    rstN = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_reset", 32'(rdy16), 32'd1);

    // Known-answer table on "123456789"; gap 0 rows run back-to-back
    for (int t = 0; t < 5; t++) begin
      c16_poly = tbl[t].p16; c16_init = tbl[t].i16; c16_ri = tbl[t].ri16;
      c16_ro = tbl[t].ro16; c16_xo = tbl[t].x16;
      c32_poly = tbl[t].p32; c32_init = tbl[t].i32; c32_ri = tbl[t].ri32;
      c32_ro = tbl[t].ro32; c32_xo = tbl[t].x32;
      send_packet(m9, tbl[t].gap, 1'b0, 32'(tbl[t].e16), tbl[t].e32);
    end

    // SOP inside a packet aborts it; a non-SOP word in IDLE is dropped
    c16_poly = 16'h8005; c16_init = 0; c16_ri = 1; c16_ro = 1; c16_xo = 0;
    c32_poly = 32'h04C11DB7; c32_init = '1; c32_ri = 1; c32_ro = 1; c32_xo = '1;
    apply_cfg();
    drive_word(32'hA1B2C3D4, 1'b1, 1'b0, 2'd3);
    drive_word(32'h0badf00d, 1'b0, 1'b0, 2'd1);
    apply_cfg();
    drive_word(32'h31323334, 1'b1, 1'b0, 2'd0);
    chk("abort_err16", 32'(e16), 32'd1);
    chk("abort_err32", 32'(e32), 32'd1);
    chk("abort_no_valid", 32'(v16), 32'd0);
    drive_word(32'h35363738, 1'b0, 1'b0, 2'd2);
    exp16_q.push_back(16'hBB3D);
    exp32_q.push_back(32'hCBF43926);
    drive_word(32'h39E7E7E7, 1'b0, 1'b1, 2'd0);
    chk("restart_valid", 32'(v16), 32'd1);
    drive_word(32'h12345678, 1'b0, 1'b0, 2'd3);
    chk("stray_err16", 32'(e16), 32'd1);
    chk("stray_no_valid", 32'(v16), 32'd0);
    chk("stray_state_idle", 32'(st16), 32'd0);
    @(posedge clk); #1;
    chk("stray_err_one_cycle", 32'(e16), 32'd0);

    // Reset in the middle of a packet
    c16_poly = 16'h1021; c16_init = 0; c16_ri = 0; c16_ro = 0; c16_xo = 0;
    apply_cfg();
    drive_word(32'h55667788, 1'b1, 1'b0, 2'd0);
    drive_word(32'h99AABBCC, 1'b0, 1'b0, 2'd0);
    rstN = 1'b0;
    #1;
    chk("midrst_crcout16", 32'(out16), 32'd0);
    chk("midrst_crcout32", out32, 32'd0);
    chk("midrst_ready", 32'(rdy16), 32'd0);
    chk("midrst_state", 32'(st16), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_valid", 32'(v16), 32'd0);
    rstN = 1'b1;
    @(posedge clk); #1;
    send_packet(m9, 1, 1'b0, 32'h31C3, 32'hCBF43926);

`ifdef CRC_STREAM_CHECK_EN
    c16_poly = 16'h8005; c16_init = 0; c16_ri = 0; c16_ro = 0; c16_xo = 0;
    send_packet(m9, 0, 1'b0, 32'hFEE8, 32'hCBF43926);
    send_packet(m9, 0, 1'b1, 32'hFEE8, 32'hCBF43926);
`endif

    // Randomised packets against the reference model
    for (int n = 0; n < 40; n++) begin
      c16_poly = 16'($urandom); c16_init = 16'($urandom); c16_ri = 1'($urandom);
      c16_ro = 1'($urandom); c16_xo = 16'($urandom);
      c32_poly = $urandom; c32_init = $urandom; c32_ri = 1'($urandom);
      c32_ro = 1'($urandom); c32_xo = $urandom;
      rq.delete();
      for (int k = 0; k < int'($urandom_range(1, 20)); k++) rq.push_back(8'($urandom));
      r16 = model_crc(rq, 16, 32'(c16_poly), 32'(c16_init), c16_ri, c16_ro, 32'(c16_xo));
      r32 = model_crc(rq, 32, c32_poly, c32_init, c32_ri, c32_ro, c32_xo);
      send_packet(rq, $urandom_range(0, 2), 1'b0, r16, r32);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("exp16_drained", 32'(exp16_q.size()), 32'd0);
    chk("exp32_drained", 32'(exp32_q.size()), 32'd0);
    chk("err16_pulses", 32'(err16_seen), 32'd2);
    chk("err32_pulses", 32'(err32_seen), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
